// File: rtl/mgt_pkg.sv
// Shared definitions for the command sequencer: FSM states, command opcodes
// and error codes.
package mgt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHECK,
    ST_ISSUE,
    ST_BUSY,
    ST_ERROR
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_BAD_CMD   = 2'b01;
  localparam logic [1:0] ERR_BAD_RANGE = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/rx_accept.sv
// Byte-acceptance handshake toward the UART receiver: one accept per rx_done
// assertion, acknowledged by a single-cycle rx_trigger on the following cycle.
module rx_accept (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_done,
  input  logic enable,
  input  logic clear,
  output logic strobe,
  output logic rx_trigger
);

  logic armed;

  assign strobe = enable && rx_done && armed;

  // armed re-arms only after rx_done has been seen low, so a held level
  // never yields a second byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      rx_trigger <= 1'b0;
    end else begin
      rx_trigger <= strobe;
      if (clear || strobe) begin
        armed <= 1'b0;
      end else if (!rx_done) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Collects a 5-byte command header from the UART, validates it and launches
// the memory engine, reporting malformed or stalled headers as error pulses.
module cmd_sequencer
  import mgt_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_done,
  output logic        rx_trigger,
  output logic        rx_owner,
  output logic [7:0]  command,
  output logic [15:0] start_address,
  output logic [15:0] end_address,
  output logic        cmd_valid,
  input  logic        engine_done,
  output logic        busy,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  state_t      state;
  logic [1:0]  idx;
  logic [23:0] timer;
  logic [7:0]  hdr_cmd;
  logic [15:0] hdr_start;
  logic [15:0] hdr_end;

  logic byte_strobe;
  logic rx_enable;
  logic leave_busy;

  assign rx_enable  = ((state == ST_IDLE) || (state == ST_HDR)) && !rx_owner;
  assign leave_busy = (state == ST_BUSY) && engine_done;

  rx_accept u_rx_accept (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_done    (rx_done),
    .enable     (rx_enable),
    .clear      (leave_busy),
    .strobe     (byte_strobe),
    .rx_trigger (rx_trigger)
  );

  // The header is gathered in shadow registers and copied to the outputs only
  // on launch, so a discarded header never disturbs the engine-facing values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      timer         <= '0;
      hdr_cmd       <= '0;
      hdr_start     <= '0;
      hdr_end       <= '0;
      rx_owner      <= 1'b0;
      command       <= '0;
      start_address <= '0;
      end_address   <= '0;
      cmd_valid     <= 1'b0;
      busy          <= 1'b0;
      err_valid     <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (byte_strobe) begin
            hdr_cmd <= rx_byte;
            idx     <= '0;
            timer   <= '0;
            state   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (byte_strobe) begin
            timer <= '0;
            case (idx)
              2'd0:    hdr_start[15:8] <= rx_byte;
              2'd1:    hdr_start[7:0]  <= rx_byte;
              2'd2:    hdr_end[15:8]   <= rx_byte;
              default: hdr_end[7:0]    <= rx_byte;
            endcase
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state <= ST_CHECK;
            end
          end else if (timer >= TIMEOUT_CYCLES - 24'd1) begin
            timer     <= '0;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= ST_ERROR;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        ST_CHECK: begin
          if (!cmd_known(hdr_cmd)) begin
            err_valid <= 1'b1;
            err_code  <= ERR_BAD_CMD;
            state     <= ST_ERROR;
          end else if (hdr_start > hdr_end) begin
            err_valid <= 1'b1;
            err_code  <= ERR_BAD_RANGE;
            state     <= ST_ERROR;
          end else begin
            command       <= hdr_cmd;
            start_address <= hdr_start;
            end_address   <= hdr_end;
            cmd_valid     <= 1'b1;
            busy          <= 1'b1;
            err_code      <= ERR_NONE;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rx_owner <= (command == CMD_WRITE);
          state    <= ST_BUSY;
        end
        ST_BUSY: begin
          if (engine_done) begin
            busy     <= 1'b0;
            rx_owner <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: stimulus pushes expected launches/errors
// into a queue, a forked monitor pops and compares whenever the DUT reports.
module tb_cmd_sequencer;

  localparam logic [23:0] TMO = 24'd40;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_done;
  logic        rx_trigger;
  logic        rx_owner;
  logic [7:0]  command;
  logic [15:0] start_address;
  logic [15:0] end_address;
  logic        cmd_valid;
  logic        engine_done;
  logic        busy;
  logic        err_valid;
  logic [1:0]  err_code;

  cmd_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_byte       (rx_byte),
    .rx_done       (rx_done),
    .rx_trigger    (rx_trigger),
    .rx_owner      (rx_owner),
    .command       (command),
    .start_address (start_address),
    .end_address   (end_address),
    .cmd_valid     (cmd_valid),
    .engine_done   (engine_done),
    .busy          (busy),
    .err_valid     (err_valid),
    .err_code      (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [7:0]  cmd;
    logic [15:0] s;
    logic [15:0] e;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   trig_count;
  int   last_trig_cyc;
  int   launches;
  int   errors;
  int   err_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_launch(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    exp_t x;
    x.is_err = 1'b0; x.cmd = c; x.s = s; x.e = e; x.code = 2'b00;
    exp_q.push_back(x);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t x;
    x.is_err = 1'b1; x.cmd = '0; x.s = '0; x.e = '0; x.code = code;
    exp_q.push_back(x);
  endtask

  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      cyc++;
      if (rx_trigger) begin
        trig_count++;
        last_trig_cyc = cyc;
      end
      if (cmd_valid) begin
        launches++;
        check("launch_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          check("launch_kind", x.is_err, 0);
          check("command", command, x.cmd);
          check("start_address", start_address, x.s);
          check("end_address", end_address, x.e);
          check("launch_err_code", err_code, 0);
          check("launch_busy", busy, 1);
          check("launch_latency", cyc - last_trig_cyc, 1);
        end
      end
      if (err_valid) begin
        errors++;
        err_cyc = cyc;
        check("error_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          check("error_kind", x.is_err, 1);
          check("err_code", err_code, x.code);
          check("error_no_launch", cmd_valid, 0);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    rx_byte = b;
    rx_done = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rx_trigger) got = 1'b1;
    end
    check("byte_acknowledged", got, 1);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
  endtask

  task automatic wait_launch(input int n0);
    for (int i = 0; i < 50 && launches == n0; i++) @(negedge clk);
    check("launch_arrived", launches > n0, 1);
  endtask

  task automatic wait_err(input int n0, input int budget);
    for (int i = 0; i < budget && errors == n0; i++) @(negedge clk);
    check("error_arrived", errors > n0, 1);
  endtask

  task automatic finish_engine();
    @(negedge clk);
    engine_done = 1'b1;
    @(negedge clk);
    engine_done = 1'b0;
    check("busy_after_done", busy, 0);
    check("owner_after_done", rx_owner, 0);
  endtask

  task automatic run_launch(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    int n0;
    n0 = launches;
    push_launch(c, s, e);
    send_hdr(c, s[15:8], s[7:0], e[15:8], e[7:0]);
    wait_launch(n0);
    @(negedge clk);
    check("busy_in_busy", busy, 1);
    check("owner_in_busy", rx_owner, (c == 8'h02));
  endtask

  function automatic logic [63:0] all_outputs();
    return {rx_trigger, rx_owner, command, start_address, end_address,
            cmd_valid, busy, err_valid, err_code};
  endfunction

  initial begin
    int n0;
    int t0;
    n_cmp = 0; n_bad = 0; cyc = 0; trig_count = 0; last_trig_cyc = 0;
    launches = 0; errors = 0; err_cyc = 0;
    rst_n = 1'b0; rx_byte = '0; rx_done = 1'b0; engine_done = 1'b0;
    fork
      monitor();
    join_none
    #2;
    check("reset_outputs", all_outputs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // engine_done while idle must have no effect
    engine_done = 1'b1;
    @(negedge clk);
    engine_done = 1'b0;
    @(negedge clk);
    check("idle_done_ignored", {busy, cmd_valid, err_valid}, 0);

    run_launch(8'h01, 16'h0010, 16'h0020);
    finish_engine();

    // write command: rx path handed to the engine, no acks from this block
    run_launch(8'h02, 16'h0000, 16'h0000);
    t0 = trig_count;
    rx_byte = 8'h55;
    rx_done = 1'b1;
    repeat (5) @(negedge clk);
    check("no_trigger_while_owned", trig_count - t0, 0);
    finish_engine();
    repeat (3) @(negedge clk);
    check("no_trigger_after_busy_exit", trig_count - t0, 0);
    rx_done = 1'b0;
    @(negedge clk);

    n0 = errors;
    push_err(2'b01);
    send_hdr(8'h07, 8'h00, 8'h00, 8'h00, 8'h01);
    wait_err(n0, 20);

    n0 = errors;
    push_err(2'b10);
    send_hdr(8'h01, 8'h00, 8'h05, 8'h00, 8'h04);
    wait_err(n0, 20);

    n0 = errors;
    push_err(2'b01);
    send_hdr(8'h03, 8'h00, 8'h09, 8'h00, 8'h01);
    wait_err(n0, 20);
    check("err_code_holds", err_code, 2'b01);

    run_launch(8'h01, 16'h1234, 16'h1234);
    finish_engine();
    run_launch(8'h02, 16'h0000, 16'hFFFF);
    finish_engine();

    // stalled header: error after roughly TMO silent cycles (off-by-one tolerant)
    n0 = errors;
    push_err(2'b11);
    send_byte(8'h01);
    send_byte(8'h00);
    wait_err(n0, 80);
    check("timeout_window", (err_cyc - last_trig_cyc >= int'(TMO) - 1) &&
                            (err_cyc - last_trig_cyc <= int'(TMO) + 1), 1);
    run_launch(8'h01, 16'h0000, 16'h0003);
    finish_engine();

    // a level held high yields exactly one byte
    t0 = trig_count;
    @(negedge clk);
    rx_byte = 8'h01;
    rx_done = 1'b1;
    repeat (4) @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
    check("one_trigger_per_level", trig_count - t0, 1);
    n0 = launches;
    push_launch(8'h01, 16'h0001, 16'h0002);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    wait_launch(n0);
    @(negedge clk);
    check("busy_before_reset", busy, 1);

    // asynchronous reset in BUSY, sampled between clock edges
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", all_outputs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("quiet_after_busy_reset", busy, 0);

    // reset mid-header: partial header abandoned, no timeout later
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n0 = errors;
    repeat (int'(TMO) + 20) @(negedge clk);
    check("no_error_after_hdr_reset", errors - n0, 0);

    run_launch(8'h02, 16'hABCD, 16'hABCE);
    finish_engine();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd100000, meaning max clk cycles allowed between header bytes.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low; this is the block's one clock and one reset.
REQ-004 SHALL have port rx_byte  input  8  byte from UART receiver.
REQ-005 SHALL have port rx_done  input  1  level; UART receiver holds a byte.
REQ-006 SHALL have port rx_trigger  output  1  one-cycle byte acknowledge to UART receiver.
REQ-007 SHALL have port rx_owner  output  1  1 = rx path granted to memory engine, 0 = to this block.
REQ-008 SHALL have port command  output  8  latched command to memory engine.
REQ-009 SHALL have port start_address  output  16  latched first address.
REQ-010 SHALL have port end_address  output  16  latched last address, inclusive.
REQ-011 SHALL have port cmd_valid  output  1  one-cycle launch pulse to memory engine.
REQ-012 SHALL have port engine_done  input  1  one-cycle completion pulse from memory engine.
REQ-013 SHALL have port busy  output  1  high from launch until engine_done.
REQ-014 SHALL have port err_valid  output  1  one-cycle error pulse.
REQ-015 SHALL have port err_code  output  2  00 none, 01 bad command, 10 bad range, 11 timeout.

Function
REQ-016 SHALL frame a header as 5 bytes: command, start hi, start lo, end hi, end lo (big-endian).
REQ-017 SHALL accept a byte only when rx_owner=0, rx_done=1 and armed; armed clears on acceptance, sets when rx_done seen 0.
REQ-018 SHALL assert rx_trigger exactly one cycle, the cycle after acceptance.
REQ-019 SHALL implement states IDLE, HDR (collect bytes 2-5, 2-bit index), CHECK, ISSUE, BUSY, ERROR.
REQ-020 IDLE: accepted byte -> command register, index=0, go HDR.
REQ-021 HDR: each accepted byte fills next address byte; after 4th go CHECK.
REQ-022 HDR: timeout counter clears on each accepted byte; reaching TIMEOUT_CYCLES -> ERROR, code 11; partial header discarded.
REQ-023 CHECK (1 cycle): command not 8'h01/8'h02 -> ERROR code 01; else start_address > end_address (unsigned) -> ERROR code 10; else ISSUE; bad command wins if both.
REQ-024 start==end SHALL be valid (one-byte transfer); 16'h0000..16'hFFFF SHALL be valid.
REQ-025 ISSUE (1 cycle): cmd_valid=1, busy=1, err_code=00, go BUSY.
REQ-026 BUSY: busy=1; rx_owner=1 iff command=8'h02; no bytes accepted; engine_done -> IDLE, busy=0 next cycle.
REQ-027 command, start_address, end_address SHALL stay stable from ISSUE through the engine_done cycle.
REQ-028 ERROR (1 cycle): err_valid=1, go IDLE; err_code holds until next ISSUE.
REQ-029 engine_done outside BUSY SHALL be ignored.
REQ-030 rx_done high on leaving BUSY SHALL not be accepted until seen low (armed=0 on BUSY exit).
REQ-031 Latency: 5th byte accepted cycle N -> CHECK N+1 -> cmd_valid N+2.

Reset
REQ-032 rst_n=0 SHALL force, asynchronously: state IDLE, all outputs 0, index 0, timeout counter 0, armed 0.
REQ-033 Reset mid-header or in BUSY SHALL abandon the transaction; no cmd_valid/err_valid after release.

Structure
REQ-034 Shared package mgt_pkg SHALL hold state encoding, CMD_READ=8'h01, CMD_WRITE=8'h02, err_code constants.
REQ-035 One sub-module rx_accept SHALL implement REQ-017/018 (armed flag, rx_trigger pulse, byte strobe).

Verification
REQ-036 Header 01 00 10 00 20 -> one cmd_valid, command=01, start=0010, end=0020, rx_owner=0; engine_done -> busy 0.
REQ-037 Header 02 00 00 00 00 -> launch, rx_owner=1 in BUSY; bytes offered then get no rx_trigger from this block.
REQ-038 Header 07 00 00 00 01 -> err_valid once, err_code=01, no cmd_valid; header 01 00 05 00 04 -> err_code=10.
REQ-039 Bytes 01 00 then silence TIMEOUT_CYCLES -> err_code=11; next full valid header launches normally.
REQ-040 rx_done held high across 2 cycles -> exactly one rx_trigger; rst_n pulsed in BUSY -> all outputs 0 asynchronously.
